// File: rtl/serial_loader.sv
// Serial-to-parallel front end: start bit, WIDTH data bits (LSB first), optional parity bit.
// Define SERIAL_LOADER_PARITY_EN to add the even-parity check state and the error strobe.
module serial_loader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             serial_valid,
  input  logic             serial_bit,
  output logic             serial_ready,
  output logic             write,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             error
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef SERIAL_LOADER_PARITY_EN
    , PARITY = 2'd3
`endif
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             accept, last_bit, load;
`ifdef SERIAL_LOADER_PARITY_EN
  logic             par_err, err_q;
`endif

  // Ready depends on state only; DONE is the single cycle that refuses bits.
  assign serial_ready = (state != DONE);
  assign accept       = clk_enable && serial_valid && serial_ready;
  assign last_bit     = (count == CW'(WIDTH - 1));
  assign busy         = (state != IDLE);
  assign write        = (state == DONE);
  assign load         = (state_next == DONE) && (state != DONE);

  always_comb begin
    state_next = state;
    count_next = count;
    shreg_next = shreg;
`ifdef SERIAL_LOADER_PARITY_EN
    par_err    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept && !serial_bit) begin
          state_next = SHIFT;
          count_next = '0;
        end
      end
      SHIFT: begin
        if (accept) begin
          for (int i = 0; i < WIDTH; i++)
            if (count == CW'(i)) shreg_next[i] = serial_bit;
          count_next = count + CW'(1);
          if (last_bit)
`ifdef SERIAL_LOADER_PARITY_EN
            state_next = PARITY;
`else
            state_next = DONE;
`endif
        end
      end
`ifdef SERIAL_LOADER_PARITY_EN
      PARITY: begin
        if (accept) begin
          if (serial_bit == ^shreg) begin
            state_next = DONE;
          end else begin
            state_next = IDLE;
            par_err    = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        if (clk_enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
      data  <= '0;
`ifdef SERIAL_LOADER_PARITY_EN
      err_q <= 1'b0;
`endif
    end else if (clk_enable) begin
      state <= state_next;
      count <= count_next;
      shreg <= shreg_next;
      // shreg_next already holds the final data bit on the entering edge
      if (load) data <= shreg_next;
`ifdef SERIAL_LOADER_PARITY_EN
      err_q <= par_err;
`endif
    end
  end

`ifdef SERIAL_LOADER_PARITY_EN
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (WIDTH=4); parity cases run when SERIAL_LOADER_PARITY_EN is defined.
module tb_serial_loader;

`ifdef SERIAL_LOADER_PARITY_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_enable = 1'b0;
  logic       serial_valid = 1'b0;
  logic       serial_bit = 1'b1;
  logic       serial_ready, write, busy, error;
  logic [3:0] data;

  int checks = 0, failures = 0;
  int cyc = 0, last_rise = 0, prev_rise = 0;
  logic wr_prev = 1'b0;
  int caps = 0;
  logic [3:0] cap_data = 4'h0;

  serial_loader #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .serial_valid(serial_valid), .serial_bit(serial_bit),
    .serial_ready(serial_ready), .write(write), .data(data),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Downstream register view: one capture per enabled edge with write high.
  always @(posedge clk)
    if (reset && clk_enable && write) begin
      caps     <= caps + 1;
      cap_data <= data;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v, input logic b, input logic en);
    serial_valid = v;
    serial_bit   = b;
    clk_enable   = en;
    @(posedge clk);
    #1;
    cyc++;
    if (write && !wr_prev) begin
      prev_rise = last_rise;
      last_rise = cyc;
    end
    wr_prev = write;
  endtask

  // Sends one frame; gaps/disabled cycles carry inverted bits that must be ignored.
  task automatic send(input logic [3:0] d, input bit flip, input int gap, input bit toggle);
    logic [5:0] fb;
    fb = {(^d) ^ flip, d, 1'b0};
    for (int i = 0; i < NB; i++) begin
      tick(1'b1, fb[i], 1'b1);
      if (i != NB - 1) begin
        repeat (gap) tick(1'b0, ~fb[i], 1'b1);
        if (toggle) tick(1'b1, ~fb[i], 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("rst_data", data, 4'h0);
    chk("rst_write", write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", serial_ready, 1'b1);
    chk("rst_error", error, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b1);

    // basic frame
    send(4'hD, 1'b0, 0, 1'b0);
    chk("basic_write", write, 1'b1);
    chk("basic_data", data, 4'hD);
    chk("basic_busy", busy, 1'b1);
    chk("basic_ready_done", serial_ready, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    chk("basic_write_drop", write, 1'b0);
    chk("basic_busy_drop", busy, 1'b0);
    chk("basic_caps", caps, 1);
    chk("basic_cap_data", cap_data, 4'hD);

    // clk_enable toggling
    send(4'hD, 1'b0, 0, 1'b1);
    chk("ce_write", write, 1'b1);
    chk("ce_data", data, 4'hD);
    tick(1'b1, 1'b0, 1'b0);
    chk("ce_write_stretch", write, 1'b1);
    chk("ce_caps_hold", caps, 1);
    tick(1'b1, 1'b1, 1'b1);
    chk("ce_write_drop", write, 1'b0);
    chk("ce_caps", caps, 2);

    // idle ones with random valid, then gapped frame
    for (int i = 0; i < 6; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    chk("idle_busy", busy, 1'b0);
    send(4'hD, 1'b0, 3, 1'b0);
    chk("gap_write", write, 1'b1);
    chk("gap_data", data, 4'hD);
    tick(1'b0, 1'b1, 1'b1);
    chk("gap_caps", caps, 3);
    chk("gap_error", error, 1'b0);

    // reset mid-frame
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", data, 4'h0);
    chk("abort_write", write, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("abort_caps", caps, 3);
    send(4'hC, 1'b0, 0, 1'b0);
    chk("after_abort_data", data, 4'hC);
    tick(1'b0, 1'b1, 1'b1);
    chk("after_abort_caps", caps, 4);
    chk("after_abort_cap_data", cap_data, 4'hC);

    // back-to-back frames; a 0 offered during DONE must be refused
    send(4'hF, 1'b0, 0, 1'b0);
    chk("b2b_ready_done", serial_ready, 1'b0);
    chk("b2b_data1", data, 4'hF);
    tick(1'b1, 1'b0, 1'b1);
    chk("b2b_ready_back", serial_ready, 1'b1);
    chk("b2b_cap1", cap_data, 4'hF);
    send(4'h0, 1'b0, 0, 1'b0);
    chk("b2b_write2", write, 1'b1);
    chk("b2b_data2", data, 4'h0);
    chk("b2b_period", last_rise - prev_rise, NB + 1);
    tick(1'b0, 1'b1, 1'b1);
    chk("b2b_caps", caps, 6);

`ifdef SERIAL_LOADER_PARITY_EN
    send(4'hD, 1'b0, 0, 1'b0);
    chk("par_ok_write", write, 1'b1);
    chk("par_ok_data", data, 4'hD);
    tick(1'b0, 1'b1, 1'b1);
    chk("par_ok_caps", caps, 7);
    send(4'hD, 1'b1, 0, 1'b0);
    chk("par_bad_error", error, 1'b1);
    chk("par_bad_write", write, 1'b0);
    chk("par_bad_busy", busy, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("par_bad_error_drop", error, 1'b0);
    chk("par_bad_data", data, 4'hD);
    chk("par_bad_caps", caps, 7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
